// File: rtl/sample_sequencer_if.sv
// Bundles the codec-side, FIR-engine-side and status signals of the sample sequencer.
// master is the sequencer itself; slave is the codec/FIR/register side.
interface sample_sequencer_if #(
  parameter int DataWidth  = 12,
  parameter int CountWidth = 8
);
  logic                  enable;
  logic                  bypass;
  logic                  clearStatus;
  logic [DataWidth-1:0]  adcData;
  logic                  adcDataValid;
  logic [DataWidth-1:0]  firSample;
  logic                  firStart;
  logic [DataWidth-1:0]  firResult;
  logic                  firDone;
  logic [DataWidth-1:0]  dacData;
  logic                  dacDataValid;
  logic                  busy;
  logic [CountWidth-1:0] overrunCount;
  logic                  timeoutFlag;

  modport master (
    input  enable, bypass, clearStatus, adcData, adcDataValid, firResult, firDone,
    output firSample, firStart, dacData, dacDataValid, busy, overrunCount, timeoutFlag
  );

  modport slave (
    output enable, bypass, clearStatus, adcData, adcDataValid, firResult, firDone,
    input  firSample, firStart, dacData, dacDataValid, busy, overrunCount, timeoutFlag
  );
endinterface

// File: rtl/sample_sequencer.sv
// Forwards each new ADC sample to the DAC, directly or through one FIR pass, with a
// completion timeout and a saturating count of samples dropped while busy.
//
// state  | meaning
// IDLE   | waiting for a new ADC sample
// START  | firStart pulse, timer cleared
// WAIT   | waiting for firDone or timeout
// OUTPUT | dacDataValid pulse
module sample_sequencer #(
  parameter int DataWidth     = 12,
  parameter int TimeoutCycles = 200,
  parameter int CountWidth    = 8
) (
  input logic                clk,
  input logic                resetN,
  sample_sequencer_if.master bus
);
  localparam int TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUTPUT} state_e;

  state_e                state_q;
  logic                  adc_valid_q;
  logic [TimerWidth-1:0] timer_q;
  logic [DataWidth-1:0]  fir_sample_q;
  logic [DataWidth-1:0]  dac_data_q;
  logic                  fir_start_q;
  logic                  dac_valid_q;
  logic                  busy_q;
  logic                  timeout_flag_q, timeout_flag_d;
  logic [CountWidth-1:0] overrun_q, overrun_d;
  logic                  new_sample;
  logic                  overrun_hit;
  logic                  timeout_hit;

  assign new_sample  = bus.adcDataValid && !adc_valid_q;
  assign overrun_hit = new_sample && (state_q != IDLE);
  assign timeout_hit = (state_q == WAIT) && !bus.firDone && (timer_q == TimerLast);

  // Clear is applied first so a coinciding overrun or timeout still registers.
  always_comb begin
    overrun_d      = overrun_q;
    timeout_flag_d = timeout_flag_q;
    if (bus.clearStatus) begin
      overrun_d      = '0;
      timeout_flag_d = 1'b0;
    end
    if (overrun_hit && !(&overrun_d)) overrun_d = overrun_d + CountWidth'(1);
    if (timeout_hit) timeout_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      adc_valid_q    <= 1'b0;
      timer_q        <= '0;
      fir_sample_q   <= '0;
      dac_data_q     <= '0;
      fir_start_q    <= 1'b0;
      dac_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      overrun_q      <= '0;
    end else begin
      adc_valid_q    <= bus.adcDataValid;
      overrun_q      <= overrun_d;
      timeout_flag_q <= timeout_flag_d;
      fir_start_q    <= 1'b0;
      dac_valid_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (new_sample && bus.enable) begin
            fir_sample_q <= bus.adcData;
            busy_q       <= 1'b1;
            if (bus.bypass) begin
              dac_data_q  <= bus.adcData;
              dac_valid_q <= 1'b1;
              state_q     <= OUTPUT;
            end else begin
              fir_start_q <= 1'b1;
              state_q     <= START;
            end
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.firDone) begin
            dac_data_q  <= bus.firResult;
            dac_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end else if (timer_q == TimerLast) begin
            dac_data_q  <= '0;
            dac_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end else begin
            timer_q <= timer_q + TimerWidth'(1);
          end
        end
        OUTPUT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.firSample    = fir_sample_q;
  assign bus.firStart     = fir_start_q;
  assign bus.dacData      = dac_data_q;
  assign bus.dacDataValid = dac_valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrunCount = overrun_q;
  assign bus.timeoutFlag  = timeout_flag_q;
endmodule
